// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-through data cache with a
// blocking miss/store controller in front of a variable-latency memory.
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   Req, WE, A, WD  memory-stage access: valid, byte enables (0 = load),
//                   byte address, store data
//   Flush           pulse to invalidate every line
//   RD, Hit         load data / load hit this cycle
//   Stall           hold the pipeline; requester keeps Req/WE/A/WD stable
//   MemReq, MemWE, MemA, MemWD   request to backing memory (MemWE 0 = read)
//   MemRD, MemAck   backing memory read data and completion strobe
//
// Loads that hit are served combinationally from the IDLE lookup. Read
// misses fill the victim way; stores always write through and only update
// the array when they hit (no write-allocate).
module assoc_cache #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 17,
    parameter int SETS          = 8,
    parameter int WAYS          = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Req,
    input  logic [DATA_WIDTH/8-1:0]  WE,
    input  logic [ADDRESS_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0]    WD,
    input  logic                     Flush,
    output logic [DATA_WIDTH-1:0]    RD,
    output logic                     Hit,
    output logic                     Stall,
    output logic                     MemReq,
    output logic [DATA_WIDTH/8-1:0]  MemWE,
    output logic [ADDRESS_WIDTH-1:0] MemA,
    output logic [DATA_WIDTH-1:0]    MemWD,
    input  logic [DATA_WIDTH-1:0]    MemRD,
    input  logic                     MemAck
);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDRESS_WIDTH - 2 - IDX;
    localparam int BW  = DATA_WIDTH / 8;
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WA  = ADDRESS_WIDTH - 2;
    localparam logic [WW-1:0] LAST_WAY = WW'(WAYS - 1);

    typedef enum logic [1:0] {IDLE, RMISS, WTHRU, DONE} state_t;
    state_t state, state_next;

    logic                  valid [SETS][WAYS];
    logic [TAG-1:0]        tags  [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data  [SETS][WAYS];
    logic [WW-1:0]         rr    [SETS];

    // Transaction registers captured when a miss or store is accepted.
    logic [WA-1:0]         addr_q;
    logic [BW-1:0]         we_q;
    logic [DATA_WIDTH-1:0] wd_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [WW-1:0]         way_q;
    logic                  store_hit_q;
    logic                  use_rr_q;
    logic                  flush_pend;

    logic [IDX-1:0]        idx, idx_q;
    logic [TAG-1:0]        tag, tag_q;
    logic                  is_load;
    logic                  hit_any, has_inv;
    logic [WW-1:0]         hit_way, inv_way, victim;
    logic [DATA_WIDTH-1:0] hit_data;
    logic                  unused_addr_bits;

    assign idx              = A[2 +: IDX];
    assign tag              = A[ADDRESS_WIDTH-1 -: TAG];
    assign idx_q            = addr_q[IDX-1:0];
    assign tag_q            = addr_q[WA-1 -: TAG];
    assign is_load          = (WE == '0);
    assign unused_addr_bits = ^A[1:0];

    // Tag compare across the ways of the addressed set. Scanning from the
    // top down leaves the lowest-index invalid way in inv_way.
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        hit_data = '0;
        has_inv  = 1'b0;
        inv_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[idx][w] && (tags[idx][w] == tag)) begin
                hit_any  = 1'b1;
                hit_way  = WW'(w);
                hit_data = data[idx][w];
            end
            if (!valid[idx][w]) begin
                has_inv = 1'b1;
                inv_way = WW'(w);
            end
        end
    end

    assign victim = has_inv ? inv_way : rr[idx];

    always_comb begin
        state_next = state;
        Stall      = 1'b0;
        Hit        = 1'b0;
        RD         = '0;
        case (state)
            IDLE: begin
                if (Req) begin
                    if (!is_load)      state_next = WTHRU;
                    else if (!hit_any) state_next = RMISS;
                    Stall = !is_load || !hit_any;
                    Hit   = is_load && hit_any;
                    RD    = (is_load && hit_any) ? hit_data : '0;
                end
            end
            RMISS, WTHRU: begin
                Stall = 1'b1;
                if (MemAck) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                RD         = rd_q;
            end
            default: state_next = IDLE;
        endcase
        // Outputs read as idle while reset is held, even with Req still high.
        if (!RST) begin
            Stall = 1'b0;
            Hit   = 1'b0;
            RD    = '0;
        end
    end

    // Memory-side outputs decode straight from the state register so they
    // never glitch on requester inputs and drop the instant reset hits.
    assign MemReq = (state == RMISS) || (state == WTHRU);
    assign MemWE  = (state == WTHRU) ? we_q : '0;
    assign MemA   = MemReq ? {addr_q, 2'b00} : '0;
    assign MemWD  = (state == WTHRU) ? wd_q : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            flush_pend  <= 1'b0;
            addr_q      <= '0;
            we_q        <= '0;
            wd_q        <= '0;
            rd_q        <= '0;
            way_q       <= '0;
            store_hit_q <= 1'b0;
            use_rr_q    <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                rr[s] <= '0;
                for (int w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    // A same-cycle hit has already been served from the
                    // pre-flush contents; a same-cycle miss refills later.
                    if (Flush) begin
                        for (int s = 0; s < SETS; s++)
                            for (int w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
                    end
                    if (Req && (!is_load || !hit_any)) begin
                        addr_q      <= A[ADDRESS_WIDTH-1:2];
                        we_q        <= WE;
                        wd_q        <= WD;
                        way_q       <= is_load ? victim : hit_way;
                        store_hit_q <= !is_load && hit_any;
                        use_rr_q    <= is_load && !has_inv;
                    end
                end
                RMISS: begin
                    if (Flush) flush_pend <= 1'b1;
                    if (MemAck) begin
                        valid[idx_q][way_q] <= 1'b1;
                        rd_q                <= MemRD;
                        if (use_rr_q)
                            rr[idx_q] <= (way_q == LAST_WAY) ? '0 : way_q + WW'(1);
                    end
                end
                WTHRU: begin
                    if (Flush) flush_pend <= 1'b1;
                    if (MemAck) rd_q <= '0;
                end
                DONE: begin
                    // Deferred flush lands here so it also drops the fill
                    // that just completed.
                    if (flush_pend || Flush) begin
                        for (int s = 0; s < SETS; s++)
                            for (int w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
                    end
                    flush_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify every read.
    always_ff @(posedge CLK) begin
        if ((state == RMISS) && MemAck) begin
            tags[idx_q][way_q] <= tag_q;
            data[idx_q][way_q] <= MemRD;
        end
        if ((state == WTHRU) && MemAck && store_hit_q) begin
            for (int b = 0; b < BW; b++)
                if (we_q[b]) data[idx_q][way_q][8*b +: 8] <= wd_q[8*b +: 8];
        end
    end

endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised N-way set-associative, write-through data cache with a blocking miss/store state machine. It sits in the memory stage between the ALU result/store-data path and data memory. Loads that hit are served combinationally. Read misses and all stores stall the pipeline while a request/acknowledge transaction completes with a variable-latency backing memory.

## Interface
- DATA_WIDTH, 32, word width; byte enables are DATA_WIDTH/8 wide.
- ADDRESS_WIDTH, 17, byte address width.
- SETS, 8, number of sets; power of two, ≥2.
- WAYS, 2, associativity; power of two, ≥1.
- Derived widths: IDX = log2(SETS), TAG = ADDRESS_WIDTH-2-IDX.

Ports (clock and reset first):
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-low.
- Req  in  1  memory-stage access valid.
- WE  in  DATA_WIDTH/8  byte enables; zero means load, nonzero means store.
- A  in  ADDRESS_WIDTH  byte address; A[1:0] ignored, index = A[2+:IDX], tag = A[ADDRESS_WIDTH-1:2+IDX].
- WD  in  DATA_WIDTH  store data.
- Flush  in  1  invalidate all lines (pulse).
- RD  out  DATA_WIDTH  load data.
- Hit  out  1  load hit this cycle.
- Stall  out  1  hold pipeline; requester keeps Req/WE/A/WD stable while high.
- MemReq  out  1  memory request valid.
- MemWE  out  DATA_WIDTH/8  memory byte enables; zero means read.
- MemA  out  ADDRESS_WIDTH  word-aligned memory address.
- MemWD  out  DATA_WIDTH  memory write data.
- MemRD  in  DATA_WIDTH  memory read data, valid with MemAck.
- MemAck  in  1  transaction complete; sampled only while MemReq=1.

## Operation
- Storage per set and way: valid bit, tag, one data word. Each set also has a log2(WAYS)-bit round-robin pointer rr.
- States: IDLE, RMISS, WTHRU, DONE.
- IDLE, Req=1, WE=0, tag match on a valid way: Hit=1, RD=way data, Stall=0. No state change.
- IDLE, Req=1, WE=0, miss: Stall=1 (combinational). Latch A and the victim way. Next state RMISS.
- IDLE, Req=1, WE≠0: Stall=1. Latch A, WE, WD, and hit way (if any). Next state WTHRU.
- RMISS: MemReq=1, MemWE=0, MemA={A[ADDRESS_WIDTH-1:2],2'b00}, Stall=1. On MemAck: write MemRD into the victim way, set valid and tag, latch MemRD as RD. Next state DONE.
- WTHRU: MemReq=1, MemWE/MemA/MemWD = latched values, Stall=1. On MemAck: if the store hit, merge enabled bytes into that way; a store miss does not allocate. Next state DONE.
- DONE: Stall=0. RD = latched fill data after RMISS, 0 after WTHRU. Hit=0; Req ignored. Next state IDLE.
- Victim choice: lowest-index invalid way; otherwise way rr[set], and rr[set] increments modulo WAYS. rr is unchanged when an invalid way is chosen.
- RD=0 and Hit=0 whenever not serving an IDLE hit or DONE.
- Flush in IDLE: all valid bits clear at the edge. A same-cycle hit is still served from pre-flush contents. If Flush coincides with a miss, the later fill sets valid normally. Flush while not in IDLE sets a pending bit; valids clear on the DONE→IDLE edge. rr is not reset by Flush.
- Reset: state IDLE, all valid bits 0, all rr 0, pending flush 0, latched registers 0. Outputs go to Stall=0, Hit=0, RD=0, MemReq=0, MemWE=0, MemA=0, MemWD=0. Reset mid-transaction abandons it immediately; MemReq falls asynchronously.

## Timing
- Load hit: 0 wait cycles; Stall never asserts.
- Read miss, MemAck in the k-th MemReq cycle (k≥1): Stall high for 1+k cycles (IDLE cycle plus k RMISS cycles), then DONE for 1 cycle. The requester advances at the end of DONE.
- Store: same timing as a read miss, whether or not it hits.
- MemReq is registered. It first rises the cycle after the request is accepted and drops the cycle after MemAck. Payload is stable throughout. Back-to-back accesses have at least one IDLE cycle between MemReq pulses.
- Tag/valid/data/rr updates take effect at the MemAck edge. The array is visible to the IDLE lookup two cycles later.

## Test plan
- After reset, load A=0x100: Stall=1, MemReq next cycle with MemA=0x100, MemWE=0; MemAck on the 3rd MemReq cycle with MemRD=0xDEADBEEF. Expect DONE with RD=0xDEADBEEF, Stall=0. Reload 0x100: Hit=1, RD=0xDEADBEEF, MemReq stays 0.
- Store WE=0001, WD=0x000000AA to 0x100 (hit): MemReq with MemWE=0001, MemWD=0x000000AA. After ack, load 0x100: Hit=1, RD=0xDEADBEAA.
- SETS=8, WAYS=2, loads to 0x000, 0x020, 0x040 (all index 0): 0x040 replaces way 0 and rr becomes 1. Load 0x000 then misses and replaces 0x020 (way 1); load 0x040 then hits.
- Store miss to 0x200: write-through observed on MemReq/MemWE/MemA/MemWD. A subsequent load of 0x200 misses (no allocate).
- Flush asserted during RMISS for 0x300: fill completes. After DONE, a load of 0x300 and of any previously cached address misses.
- Drive RST=0 while MemReq=1 in RMISS: MemReq=0 and Stall=0 immediately. After release, a load of previously cached 0x100 misses.
